reaction_timer: RTL and testbench
=================================

Name: reaction_timer

Overview:
- Player-side measurement block for the reaction game.
- It is armed for a round, receives the one-cycle `go` pulse when the start cue appears, then counts elapsed milliseconds until the player presses the button.
- It reports the result in BCD and drives four active-low 7-segment digits.
- It flags a false start (a press before `go`) and a timeout (no press by 9999 ms).

Parameters:
- TICKS_PER_MS, 50000, clk cycles per millisecond; must be >= 2. Use 4 in simulation.
- MAX_MS_BCD, 16'h9999, BCD saturation value that triggers timeout.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- arm  input  1  one-cycle pulse; start/restart a round
- go  input  1  one-cycle pulse; start cue has just been shown
- btn_n  input  1  raw player key, active-low, asynchronous to clk
- busy  output  1  high in ARMED or TIMING
- result_valid  output  1  high in DONE
- false_start  output  1  high in FAULT
- timed_out  output  1  high in DONE when saturated with no press
- ms_bcd  output  16  four BCD digits of elapsed ms; [3:0] is ones
- hex0..hex3  output  7 each  active-low segments {g,f,e,d,c,b,a}; hex0 is ones

Behaviour:
- All state is in flops with an async reset. Reset values:
  - state = IDLE
  - ms_bcd = 0, prescaler = 0
  - sync flops = 1 (released)
  - all flags = 0
  - hex0..3 = 7'h7F (blank)
- Reset mid-round returns to exactly these values.
- Button path:
  - 2-flop synchronizer, then an edge register.
  - press = synchronized falling edge (1 then 0).
  - A pin transition becomes a press pulse 3 cycles later.
  - A held button produces exactly one press.
  - A button already held when `arm` arrives produces no press.
- FSM states: IDLE, ARMED, TIMING, DONE, FAULT.
- `arm` in any state has top priority:
  - next state = ARMED
  - ms_bcd, prescaler and flags cleared
  - same-cycle go/press ignored
- IDLE: waits for `arm`; go and press are ignored.
- ARMED:
  - press -> FAULT.
  - go -> TIMING, prescaler cleared.
  - press and go in the same cycle -> FAULT (false start wins).
- TIMING:
  - The prescaler counts 0..TICKS_PER_MS-1 and wraps.
  - On each wrap cycle, ms_bcd increments as a decimal ripple (digit 9 -> 0 with carry).
  - The first increment occurs TICKS_PER_MS cycles after TIMING entry.
  - press -> DONE, ms_bcd frozen. A press in the same cycle as a wrap takes the increment, then freezes.
  - When ms_bcd reaches MAX_MS_BCD: -> DONE with timed_out = 1. ms_bcd never wraps past 9999.
- DONE and FAULT: hold all outputs. go and press are ignored until `arm` or reset.
- Hex decoding is combinational from registered state and ms_bcd:
  - IDLE: all blank (7'h7F).
  - ARMED, TIMING, DONE: digits of ms_bcd, standard 0-9 patterns (0 = 7'b1000000, 7 = 7'b1111000).
  - FAULT: all dash (7'b0111111).
- Output flags are decoded from the state register: no glitches and no extra latency.

Decomposition:
- Package `game_pkg` holds:
  - the state enum (`rt_state_t`)
  - the 7-seg constants `SEG_BLANK` and `SEG_DASH`
  - the `seg_digit` function/LUT for BCD 0-9
- One sub-module, `bcd_counter4`: 4-digit BCD incrementer with clear, enable and saturation.
  - It is instantiated once here and is reusable for score displays.

Test Plan (TICKS_PER_MS = 4):
1. Normal round: arm; go 5 cycles later; btn_n low 948 cycles after go, accounting for the 3-cycle press latency -> DONE, ms_bcd = 16'h0237, result_valid = 1, hex0 = 7'b1111000, hex2 = 7'b0100100, busy = 0.
2. False start: arm; btn_n low before go -> after 3 cycles false_start = 1, hex0..3 = 7'b0111111. A later go leaves the state unchanged.
3. Tie: the press pulse and go land in the same cycle -> FAULT, ms_bcd = 0.
4. Timeout: arm, go, no press -> after 9999 × 4 cycles ms_bcd = 16'h9999, timed_out = 1, result_valid = 1, and the count stays frozen thereafter.
5. Held key and re-arm: in DONE with btn_n held low, pulse arm -> ARMED, ms_bcd = 0. go then starts TIMING with no spurious press; release and re-press -> DONE.
6. Async reset: assert reset at ms_bcd = 16'h0051 in TIMING, between clock edges -> outputs reach their reset values immediately (hex = 7'h7F). After release the block sits in IDLE and ignores go.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and 7-segment helpers for the reaction game blocks.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_TIMING = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } rt_state_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // BCD digit to active-low segment pattern; non-decimal codes show blank.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, enable and saturation.
// hits_max tells the owner that the next enabled increment lands on MAX_BCD.
module bcd_counter4 #(
  parameter logic [15:0] MAX_BCD = 16'h9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] count,
  output logic        hits_max
);

  logic [15:0] nxt;
  logic        carry;

  // Decimal ripple increment: a 9 rolls to 0 and carries into the next digit.
  always_comb begin
    nxt   = count;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          nxt[4*i +: 4] = 4'd0;
        end else begin
          nxt[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  assign hits_max = (nxt == MAX_BCD);

  // Count register: clear wins, and the value never moves past MAX_BCD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 16'h0000;
    end else if (clr) begin
      count <= 16'h0000;
    end else if (en && (count != MAX_BCD)) begin
      count <= nxt;
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// Player-side reaction measurement: arm, wait for go, count ms until press.
// Result handshake: result_valid is high from DONE entry until the next arm or
// reset, and ms_bcd / timed_out are stable for the whole time it is high.
module reaction_timer
  import game_pkg::*;
#(
  parameter int          TICKS_PER_MS = 50000,
  parameter logic [15:0] MAX_MS_BCD   = 16'h9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arm,
  input  logic        go,
  input  logic        btn_n,
  output logic        busy,
  output logic        result_valid,
  output logic        false_start,
  output logic        timed_out,
  output logic [15:0] ms_bcd,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3
);

  localparam int PW = (TICKS_PER_MS > 2) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);

  rt_state_t     state;
  logic [PW-1:0] presc;
  logic          sync1, sync2, btn_prev;
  logic          press;
  logic          wrap;
  logic          cnt_en;
  logic          hits_max;

  // Two-flop synchronizer plus edge register; released (1) out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      btn_prev <= 1'b1;
    end else begin
      sync1    <= btn_n;
      sync2    <= sync1;
      btn_prev <= sync2;
    end
  end

  // A press is the synchronized 1 -> 0 transition; a held key yields one press.
  assign press  = btn_prev & ~sync2;
  assign wrap   = (presc == PRESC_LAST);
  assign cnt_en = (state == ST_TIMING) && wrap && !arm;

  bcd_counter4 #(.MAX_BCD(MAX_MS_BCD)) u_ms (
    .clk      (clk),
    .reset    (reset),
    .clr      (arm),
    .en       (cnt_en),
    .count    (ms_bcd),
    .hits_max (hits_max)
  );

  // Round FSM with prescaler; flags are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      presc        <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timed_out    <= 1'b0;
    end else if (arm) begin
      state        <= ST_ARMED;
      presc        <= '0;
      busy         <= 1'b1;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      case (state)
        ST_ARMED: begin
          if (press) begin
            state       <= ST_FAULT;
            busy        <= 1'b0;
            false_start <= 1'b1;
          end else if (go) begin
            state <= ST_TIMING;
            presc <= '0;
          end
        end
        ST_TIMING: begin
          presc <= wrap ? '0 : presc + PW'(1);
          if (press) begin
            state        <= ST_DONE;
            busy         <= 1'b0;
            result_valid <= 1'b1;
          end else if (wrap && hits_max) begin
            state        <= ST_DONE;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            timed_out    <= 1'b1;
          end
        end
        default: begin
          // IDLE, DONE and FAULT hold until arm or reset.
        end
      endcase
    end
  end

  // Display decode from the registered state and count.
  always_comb begin
    hex0 = SEG_BLANK;
    hex1 = SEG_BLANK;
    hex2 = SEG_BLANK;
    hex3 = SEG_BLANK;
    case (state)
      ST_ARMED, ST_TIMING, ST_DONE: begin
        hex0 = seg_digit(ms_bcd[3:0]);
        hex1 = seg_digit(ms_bcd[7:4]);
        hex2 = seg_digit(ms_bcd[11:8]);
        hex3 = seg_digit(ms_bcd[15:12]);
      end
      ST_FAULT: begin
        hex0 = SEG_DASH;
        hex1 = SEG_DASH;
        hex2 = SEG_DASH;
        hex3 = SEG_DASH;
      end
      default: begin
        hex0 = SEG_BLANK;
        hex1 = SEG_BLANK;
        hex2 = SEG_BLANK;
        hex3 = SEG_BLANK;
      end
    endcase
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer with a small arithmetic model of the game rules.
module tb_reaction_timer;

  localparam int TICKS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic        go = 1'b0;
  logic        btn_n = 1'b1;
  logic        busy, result_valid, false_start, timed_out;
  logic [15:0] ms_bcd;
  logic [6:0]  hex0, hex1, hex2, hex3;

  int total = 0;
  int bad = 0;

  wire [3:0]  flags = {busy, result_valid, false_start, timed_out};
  wire [27:0] hexes = {hex3, hex2, hex1, hex0};

  logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [27:0] ALL_BLANK = {4{7'h7F}};
  localparam logic [27:0] ALL_DASH  = {4{7'b0111111}};

  reaction_timer #(.TICKS_PER_MS(TICKS), .MAX_MS_BCD(16'h9999)) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .go           (go),
    .btn_n        (btn_n),
    .busy         (busy),
    .result_valid (result_valid),
    .false_start  (false_start),
    .timed_out    (timed_out),
    .ms_bcd       (ms_bcd),
    .hex0         (hex0),
    .hex1         (hex1),
    .hex2         (hex2),
    .hex3         (hex3)
  );

  // Clock: 10 time units per cycle.
  always #5 clk = ~clk;

  // Advance n rising edges; inputs are driven and outputs sampled 1 unit later.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return 16'(((n / 1000) % 10) * 4096 + ((n / 100) % 10) * 256 +
               ((n / 10) % 10) * 16 + (n % 10));
  endfunction

  function automatic logic [27:0] exp_hex(input logic [15:0] b);
    logic [3:0] d3, d2, d1, d0;
    d3 = b[15:12]; d2 = b[11:8]; d1 = b[7:4]; d0 = b[3:0];
    return {seg_ref[d3], seg_ref[d2], seg_ref[d1], seg_ref[d0]};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    cyc(2);
    total++; if (flags !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want %b", flags, 4'b0000); end
    total++; if (ms_bcd !== 16'h0000) begin bad++; $display("FAIL reset_ms: got %h want %h", ms_bcd, 16'h0000); end
    total++; if (hexes !== ALL_BLANK) begin bad++; $display("FAIL reset_hex: got %h want %h", hexes, ALL_BLANK); end
    reset = 1'b0;
    cyc(2);
    // IDLE ignores go and presses.
    go = 1'b1; cyc(1); go = 1'b0;
    btn_n = 1'b0; cyc(6);
    total++; if (flags !== 4'b0000) begin bad++; $display("FAIL idle_ignore_flags: got %b want %b", flags, 4'b0000); end
    total++; if (hexes !== ALL_BLANK) begin bad++; $display("FAIL idle_ignore_hex: got %h want %h", hexes, ALL_BLANK); end
    btn_n = 1'b1; cyc(4);
  endtask

  // One full round: press pin falls j cycles after the go edge.
  task automatic run_round(input int gdly, input int j, input bit rel);
    int k;
    logic [15:0] exp_ms;
    btn_n = 1'b1; cyc(4);
    arm = 1'b1; cyc(1); arm = 1'b0;
    cyc(gdly);
    go = 1'b1; cyc(1); go = 1'b0;
    cyc(j);
    btn_n = 1'b0;
    k = 0;
    while (!result_valid && k < 12) begin cyc(1); k++; end
    exp_ms = to_bcd((j + 3) / TICKS);
    total++; if (k !== 3) begin bad++; $display("FAIL press_latency: got %0d want %0d", k, 3); end
    total++; if (ms_bcd !== exp_ms) begin bad++; $display("FAIL round_ms j=%0d: got %h want %h", j, ms_bcd, exp_ms); end
    total++; if (flags !== 4'b0100) begin bad++; $display("FAIL round_flags: got %b want %b", flags, 4'b0100); end
    total++; if (hexes !== exp_hex(exp_ms)) begin bad++; $display("FAIL round_hex: got %h want %h", hexes, exp_hex(exp_ms)); end
    if (rel) begin btn_n = 1'b1; cyc(4); end
  endtask

  task automatic test_normal();
    run_round(5, 945, 1'b1);   // 948 cycles to the press edge -> 237 ms
    for (int i = 0; i < 6; i++)
      run_round(int'($urandom_range(1, 8)), int'($urandom_range(0, 600)), 1'b1);
  endtask

  task automatic test_false_start();
    int gdly;
    gdly = int'($urandom_range(0, 3));
    btn_n = 1'b1; cyc(4);
    arm = 1'b1; cyc(1); arm = 1'b0;
    btn_n = 1'b0;
    cyc(2);
    total++; if (flags !== 4'b1000) begin bad++; $display("FAIL fs_before: got %b want %b", flags, 4'b1000); end
    cyc(1);
    total++; if (flags !== 4'b0010) begin bad++; $display("FAIL fs_flags: got %b want %b", flags, 4'b0010); end
    total++; if (hexes !== ALL_DASH) begin bad++; $display("FAIL fs_hex: got %h want %h", hexes, ALL_DASH); end
    cyc(gdly);
    go = 1'b1; cyc(1); go = 1'b0;
    cyc(8);
    total++; if (flags !== 4'b0010 || ms_bcd !== 16'h0000) begin bad++; $display("FAIL fs_go_ignored: got %b/%h want %b/%h", flags, ms_bcd, 4'b0010, 16'h0000); end
    btn_n = 1'b1; cyc(4);
  endtask

  task automatic test_tie();
    btn_n = 1'b1; cyc(4);
    arm = 1'b1; cyc(1); arm = 1'b0;
    btn_n = 1'b0;
    cyc(2);
    go = 1'b1; cyc(1); go = 1'b0;
    total++; if (flags !== 4'b0010) begin bad++; $display("FAIL tie_flags: got %b want %b", flags, 4'b0010); end
    cyc(6);
    total++; if (ms_bcd !== 16'h0000) begin bad++; $display("FAIL tie_ms: got %h want %h", ms_bcd, 16'h0000); end
    btn_n = 1'b1; cyc(4);
  endtask

  task automatic test_timeout();
    int k;
    btn_n = 1'b1; cyc(4);
    arm = 1'b1; cyc(1); arm = 1'b0;
    cyc(3);
    go = 1'b1; cyc(1); go = 1'b0;
    k = 0;
    while (!result_valid && k < 40100) begin cyc(1); k++; end
    total++; if (k !== 9999 * TICKS) begin bad++; $display("FAIL timeout_cycles: got %0d want %0d", k, 9999 * TICKS); end
    total++; if (ms_bcd !== 16'h9999) begin bad++; $display("FAIL timeout_ms: got %h want %h", ms_bcd, 16'h9999); end
    total++; if (flags !== 4'b0101) begin bad++; $display("FAIL timeout_flags: got %b want %b", flags, 4'b0101); end
    btn_n = 1'b0; cyc(20);
    total++; if (ms_bcd !== 16'h9999 || flags !== 4'b0101) begin bad++; $display("FAIL timeout_frozen: got %h/%b want %h/%b", ms_bcd, flags, 16'h9999, 4'b0101); end
    total++; if (hexes !== exp_hex(16'h9999)) begin bad++; $display("FAIL timeout_hex: got %h want %h", hexes, exp_hex(16'h9999)); end
    btn_n = 1'b1; cyc(4);
  endtask

  task automatic test_rearm_held();
    int m, k;
    logic [15:0] exp_ms;
    run_round(2, int'($urandom_range(10, 80)), 1'b0);
    arm = 1'b1; cyc(1); arm = 1'b0;
    total++; if (flags !== 4'b1000 || ms_bcd !== 16'h0000) begin bad++; $display("FAIL rearm_state: got %b/%h want %b/%h", flags, ms_bcd, 4'b1000, 16'h0000); end
    cyc(10);
    total++; if (flags !== 4'b1000) begin bad++; $display("FAIL rearm_no_press: got %b want %b", flags, 4'b1000); end
    go = 1'b1; cyc(1); go = 1'b0;
    m = 0;
    cyc(10); m += 10;
    total++; if (flags !== 4'b1000) begin bad++; $display("FAIL held_timing: got %b want %b", flags, 4'b1000); end
    btn_n = 1'b1; cyc(4); m += 4;
    btn_n = 1'b0;
    k = 0;
    while (!result_valid && k < 12) begin cyc(1); k++; end
    exp_ms = to_bcd((m + 3) / TICKS);
    total++; if (ms_bcd !== exp_ms || flags !== 4'b0100) begin bad++; $display("FAIL repress: got %h/%b want %h/%b", ms_bcd, flags, exp_ms, 4'b0100); end
    btn_n = 1'b1; cyc(4);
  endtask

  task automatic test_async_reset();
    int k;
    arm = 1'b1; cyc(1); arm = 1'b0;
    go = 1'b1; cyc(1); go = 1'b0;
    k = 0;
    while (ms_bcd !== 16'h0051 && k < 300) begin cyc(1); k++; end
    total++; if (k !== 51 * TICKS) begin bad++; $display("FAIL reach_51: got %0d want %0d", k, 51 * TICKS); end
    #2 reset = 1'b1;
    #1;
    total++; if (flags !== 4'b0000 || ms_bcd !== 16'h0000) begin bad++; $display("FAIL async_reset_state: got %b/%h want %b/%h", flags, ms_bcd, 4'b0000, 16'h0000); end
    total++; if (hexes !== ALL_BLANK) begin bad++; $display("FAIL async_reset_hex: got %h want %h", hexes, ALL_BLANK); end
    #3 reset = 1'b0;
    cyc(2);
    go = 1'b1; cyc(1); go = 1'b0;
    cyc(12);
    total++; if (flags !== 4'b0000 || ms_bcd !== 16'h0000 || hexes !== ALL_BLANK) begin bad++; $display("FAIL post_reset_idle: got %b/%h/%h want %b/%h/%h", flags, ms_bcd, hexes, 4'b0000, 16'h0000, ALL_BLANK); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_false_start();
    test_tie();
    test_timeout();
    test_rearm_held();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
